// File: rtl/vga_timing_detector.sv
// Measures VGA line/frame timing (h_total, hsync width, v_total, vsync width) and tracks lock.
// Latency: measurement outputs and pulses change 2 enabled clock edges after the vsync leading edge.
// Backpressure: none; every enabled cycle is consumed, while detector_enable low freezes all state.
module vga_timing_detector #(
   parameter int   WIDTH       = 11,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic             control_clock,
   input  logic             control_reset_n,
   input  logic             detector_enable,
   input  logic             hsync_in,
   input  logic             vsync_in,
   output logic [WIDTH-1:0] h_total,
   output logic [WIDTH-1:0] h_sync_width,
   output logic [WIDTH-1:0] v_total,
   output logic [WIDTH-1:0] v_sync_width,
   output logic             timing_update,
   output logic             timing_locked,
   output logic             timing_error
);

   typedef enum logic [1:0] {SEARCH, MEASURE, CHECK, LOCKED} state_t;

   localparam logic [WIDTH-1:0] CNT_MAX = '1;
   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   // sync sampling stages: q is the newest enabled sample, qq the one before
   logic hs_q, hs_qq, vs_q, vs_qq;

   // counters and per-frame captures
   logic [WIDTH-1:0] h_cnt_q, h_cnt_d;
   logic [WIDTH-1:0] v_cnt_q, v_cnt_d;
   logic [WIDTH-1:0] hw_q, hw_d;
   logic [WIDTH-1:0] vw_q, vw_d;
   logic [WIDTH-1:0] ref_q, ref_d;
   logic             ref_vld_q, ref_vld_d;
   logic             unstable_q, unstable_d;

   // published results and pulses
   logic [WIDTH-1:0] h_total_q, h_total_d;
   logic [WIDTH-1:0] h_sync_width_q, h_sync_width_d;
   logic [WIDTH-1:0] v_total_q, v_total_d;
   logic [WIDTH-1:0] v_sync_width_q, v_sync_width_d;
   logic             upd_q, upd_d;
   logic             err_q, err_d;
   state_t           state_q, state_d;

   logic hs_lead, hs_trail, vs_lead, vs_trail;
   logic h_ovf, v_ovf;
   logic line_bad, frame_unstable, frame_match;
   logic [WIDTH-1:0] h_meas;

   // edges are only meaningful on enabled cycles, so the stages can freeze across gaps
   assign hs_lead  = detector_enable && (hs_q == SYNC_ACTIVE) && (hs_qq != SYNC_ACTIVE);
   assign hs_trail = detector_enable && (hs_q != SYNC_ACTIVE) && (hs_qq == SYNC_ACTIVE);
   assign vs_lead  = detector_enable && (vs_q == SYNC_ACTIVE) && (vs_qq != SYNC_ACTIVE);
   assign vs_trail = detector_enable && (vs_q != SYNC_ACTIVE) && (vs_qq == SYNC_ACTIVE);

   // counters, width captures and the per-frame line-period reference
   always_comb begin
      h_cnt_d    = h_cnt_q;
      v_cnt_d    = v_cnt_q;
      hw_d       = hw_q;
      vw_d       = vw_q;
      ref_d      = ref_q;
      ref_vld_d  = ref_vld_q;
      unstable_d = unstable_q;
      h_ovf      = 1'b0;
      v_ovf      = 1'b0;

      // horizontal counter: restart at 1 on each line start, otherwise count enabled cycles
      if (hs_lead) begin
         h_cnt_d = CNT_ONE;
      end else if (detector_enable) begin
         if (h_cnt_q == CNT_MAX) begin
            h_ovf   = 1'b1;
            h_cnt_d = '0;
         end else begin
            h_cnt_d = h_cnt_q + CNT_ONE;
         end
      end

      if (hs_trail) begin
         hw_d = h_cnt_q;
      end

      // line counter: the frame start wins over the coinciding line start, so that
      // line becomes line 1 of the new frame
      if (vs_lead) begin
         v_cnt_d = CNT_ONE;
      end else if (hs_lead) begin
         if (v_cnt_q == CNT_MAX) begin
            v_ovf   = 1'b1;
            v_cnt_d = '0;
         end else begin
            v_cnt_d = v_cnt_q + CNT_ONE;
         end
      end

      if (vs_trail) begin
         vw_d = v_cnt_q;
      end

      // the period closed at a line start is checked against the frame's first period;
      // the period closed at the frame start still belongs to the frame that is ending
      if (vs_lead) begin
         ref_vld_d  = 1'b0;
         unstable_d = 1'b0;
      end else if (hs_lead) begin
         if (!ref_vld_q) begin
            ref_d     = h_cnt_q;
            ref_vld_d = 1'b1;
         end
         unstable_d = unstable_q | line_bad;
      end
   end

   assign line_bad       = hs_lead && ref_vld_q && (h_cnt_q != ref_q);
   assign frame_unstable = unstable_q | line_bad;
   assign h_meas         = ref_vld_q ? ref_q : h_cnt_q;
   assign frame_match    = (h_meas == h_total_q) && (hw_q == h_sync_width_q) &&
                           (v_cnt_q == v_total_q) && (vw_q == v_sync_width_q);

   // lock FSM next state, publish decision and one-cycle pulses
   always_comb begin
      state_d        = state_q;
      upd_d          = 1'b0;
      err_d          = 1'b0;
      h_total_d      = h_total_q;
      h_sync_width_d = h_sync_width_q;
      v_total_d      = v_total_q;
      v_sync_width_d = v_sync_width_q;

      if (h_ovf || v_ovf) begin
         err_d   = 1'b1;
         state_d = SEARCH;
      end else if (vs_lead) begin
         case (state_q)
            SEARCH: begin
               state_d = MEASURE;
            end
            MEASURE, CHECK, LOCKED: begin
               if (frame_unstable) begin
                  err_d   = 1'b1;
                  state_d = SEARCH;
               end else begin
                  upd_d = 1'b1;
                  if (state_q == MEASURE) begin
                     state_d = CHECK;
                  end else if (state_q == CHECK) begin
                     state_d = frame_match ? LOCKED : CHECK;
                  end else begin
                     state_d = frame_match ? LOCKED : CHECK;
                  end
                  // a matching frame republishes identical values, so publishing is unconditional
                  h_total_d      = h_meas;
                  h_sync_width_d = hw_q;
                  v_total_d      = v_cnt_q;
                  v_sync_width_d = vw_q;
               end
            end
            default: begin
               state_d = SEARCH;
            end
         endcase
      end
   end

   // sync stages advance only on enabled cycles
   always_ff @(posedge control_clock or negedge control_reset_n) begin
      if (!control_reset_n) begin
         hs_q  <= 1'b0;
         hs_qq <= 1'b0;
         vs_q  <= 1'b0;
         vs_qq <= 1'b0;
      end else if (detector_enable) begin
         hs_q  <= hsync_in;
         hs_qq <= hs_q;
         vs_q  <= vsync_in;
         vs_qq <= vs_q;
      end
   end

   // measurement datapath registers
   always_ff @(posedge control_clock or negedge control_reset_n) begin
      if (!control_reset_n) begin
         h_cnt_q    <= '0;
         v_cnt_q    <= '0;
         hw_q       <= '0;
         vw_q       <= '0;
         ref_q      <= '0;
         ref_vld_q  <= 1'b0;
         unstable_q <= 1'b0;
      end else begin
         h_cnt_q    <= h_cnt_d;
         v_cnt_q    <= v_cnt_d;
         hw_q       <= hw_d;
         vw_q       <= vw_d;
         ref_q      <= ref_d;
         ref_vld_q  <= ref_vld_d;
         unstable_q <= unstable_d;
      end
   end

   // FSM state and published outputs
   always_ff @(posedge control_clock or negedge control_reset_n) begin
      if (!control_reset_n) begin
         state_q        <= SEARCH;
         upd_q          <= 1'b0;
         err_q          <= 1'b0;
         h_total_q      <= '0;
         h_sync_width_q <= '0;
         v_total_q      <= '0;
         v_sync_width_q <= '0;
      end else begin
         state_q        <= state_d;
         upd_q          <= upd_d;
         err_q          <= err_d;
         h_total_q      <= h_total_d;
         h_sync_width_q <= h_sync_width_d;
         v_total_q      <= v_total_d;
         v_sync_width_q <= v_sync_width_d;
      end
   end

   assign h_total       = h_total_q;
   assign h_sync_width  = h_sync_width_q;
   assign v_total       = v_total_q;
   assign v_sync_width  = v_sync_width_q;
   assign timing_update = upd_q;
   assign timing_error  = err_q;
   assign timing_locked = (state_q == LOCKED);

endmodule

// File: tb/tb_vga_timing_detector.sv
// Scoreboard bench for vga_timing_detector using a scaled-down raster (40/6 x 12/2, alt 44).
// Expected events are queued before each frame; a monitor compares them on update/error pulses.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_vga_timing_detector;

   localparam int W = 11;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic          hs;
   logic          vs;
   logic [W-1:0]  h_total, h_sync_width, v_total, v_sync_width;
   logic          timing_update, timing_locked, timing_error;

   typedef struct packed {
      logic         err;
      logic [W-1:0] h;
      logic [W-1:0] hw;
      logic [W-1:0] v;
      logic [W-1:0] vw;
      logic         locked;
   } ev_t;

   ev_t exp_q[$];
   int  checks   = 0;
   int  failures = 0;
   int  item_no  = 0;
   bit  half_rate = 1'b0;

   always #5 clk = ~clk;

   vga_timing_detector #(.WIDTH(W), .SYNC_ACTIVE(1'b0)) dut (
      .control_clock   (clk),
      .control_reset_n (rst_n),
      .detector_enable (en),
      .hsync_in        (hs),
      .vsync_in        (vs),
      .h_total         (h_total),
      .h_sync_width    (h_sync_width),
      .v_total         (v_total),
      .v_sync_width    (v_sync_width),
      .timing_update   (timing_update),
      .timing_locked   (timing_locked),
      .timing_error    (timing_error)
   );

   // one pixel: inputs held for one enabled cycle (followed by a disabled cycle at half rate)
   task automatic pix(input logic h, input logic v);
      @(negedge clk);
      hs = h;
      vs = v;
      en = 1'b1;
      if (half_rate) begin
         @(negedge clk);
         en = 1'b0;
      end
   endtask

   // active-low syncs; line bad_line is one pixel short; only the first n_lines are sent
   task automatic send_frame(input int h, input int hw, input int v, input int vw,
                             input int bad_line, input int n_lines);
      for (int l = 0; l < v; l++) begin
         if (l < n_lines) begin
            for (int c = 0; c < ((l == bad_line) ? h - 1 : h); c++) begin
               pix((c < hw) ? 1'b0 : 1'b1, (l < vw) ? 1'b0 : 1'b1);
            end
         end
      end
   endtask

   task automatic frame_a();
      send_frame(40, 6, 12, 2, -1, 12);
   endtask

   task automatic push(input logic err, input int h, input int hw, input int v,
                       input int vw, input logic locked);
      ev_t e;
      e.err    = err;
      e.h      = W'(h);
      e.hw     = W'(hw);
      e.v      = W'(v);
      e.vw     = W'(vw);
      e.locked = locked;
      exp_q.push_back(e);
   endtask

   task automatic check_zero(input string name);
      logic [4*W+2:0] act;
      act = {h_total, h_sync_width, v_total, v_sync_width,
             timing_update, timing_locked, timing_error};
      checks++;
      if (act !== '0) begin
         failures++;
         $display("FAIL %s: outputs h=%0d hw=%0d v=%0d vw=%0d upd=%0b lock=%0b err=%0b, all must be 0",
                  name, h_total, h_sync_width, v_total, v_sync_width,
                  timing_update, timing_locked, timing_error);
      end
   endtask

   // monitor: every update/error pulse must match the oldest queued expectation
   initial begin
      ev_t act;
      ev_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && (timing_update === 1'b1 || timing_error === 1'b1)) begin
            act.err    = timing_error;
            act.h      = h_total;
            act.hw     = h_sync_width;
            act.v      = v_total;
            act.vw     = v_sync_width;
            act.locked = timing_locked;
            item_no++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL event %0d unexpected: err=%0b upd=%0b h=%0d hw=%0d v=%0d vw=%0d lock=%0b, none expected",
                        item_no, timing_error, timing_update, act.h, act.hw, act.v, act.vw, act.locked);
            end else begin
               e = exp_q.pop_front();
               if (act !== e || timing_update === timing_error) begin
                  failures++;
                  $display("FAIL event %0d: got err=%0b upd=%0b h=%0d hw=%0d v=%0d vw=%0d lock=%0b, want err=%0b h=%0d hw=%0d v=%0d vw=%0d lock=%0b",
                           item_no, act.err, timing_update, act.h, act.hw, act.v, act.vw, act.locked,
                           e.err, e.h, e.hw, e.v, e.vw, e.locked);
               end
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      hs    = 1'b1;
      vs    = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_zero("reset_state");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) pix(1'b1, 1'b1);

      // first lock at full rate
      frame_a();                                   // SEARCH -> MEASURE
      push(1'b0, 40, 6, 12, 2, 1'b0); frame_a();   // first publish, CHECK
      push(1'b0, 40, 6, 12, 2, 1'b1); frame_a();   // matching frame, LOCKED
      // one short line while locked -> error, outputs held, back to SEARCH
      push(1'b0, 40, 6, 12, 2, 1'b1); send_frame(40, 6, 12, 2, 3, 12);
      push(1'b1, 40, 6, 12, 2, 1'b0); frame_a();   // unstable frame rejected
      frame_a();                                   // SEARCH -> MEASURE, no event
      push(1'b0, 40, 6, 12, 2, 1'b0); frame_a();
      // mode change while locked
      push(1'b0, 40, 6, 12, 2, 1'b1); send_frame(44, 6, 12, 2, -1, 12);
      push(1'b0, 44, 6, 12, 2, 1'b0); send_frame(44, 6, 12, 2, -1, 12);
      push(1'b0, 44, 6, 12, 2, 1'b1); send_frame(40, 6, 12, 2, -1, 5);

      // reset mid-frame while locked
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_zero("midframe_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) pix(1'b1, 1'b1);
      frame_a();                                   // SEARCH -> MEASURE
      push(1'b0, 40, 6, 12, 2, 1'b0); frame_a();   // second edge, not yet locked
      push(1'b0, 40, 6, 12, 2, 1'b1); send_frame(40, 6, 12, 2, -1, 3);

      // half-rate enable from a clean reset
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_zero("second_reset");
      @(negedge clk);
      rst_n = 1'b1;
      half_rate = 1'b1;
      repeat (5) pix(1'b1, 1'b1);
      frame_a();
      push(1'b0, 40, 6, 12, 2, 1'b0); frame_a();
      push(1'b0, 40, 6, 12, 2, 1'b1); frame_a();
      half_rate = 1'b0;

      // hsync stuck inactive: horizontal counter overflows while locked
      push(1'b1, 40, 6, 12, 2, 1'b0);
      repeat (2100) pix(1'b1, 1'b1);

      repeat (20) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL pending_events: %0d expected events never seen, want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
